// File: rtl/ucode_sequencer.sv
// Microcode sequencer: steps CALL/RET (and optionally IRQ) micro-op ROM addresses after a macro opcode.
// Define UCODE_IRQ_EN to build the interrupt-entry sequence and the irq_req/irq_ack ports.
module ucode_sequencer #(
    parameter int         INST_WIDTH = 32,
    parameter int         SC_WIDTH   = 8,
    parameter logic [6:0] CALL_OPC   = 7'h70,
    parameter logic [6:0] RET_OPC    = 7'h71,
    parameter int         CALL_LEN   = 16,
    parameter int         RET_LEN    = 16
`ifdef UCODE_IRQ_EN
    ,
    parameter int         IRQ_LEN    = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] inst_in,
    input  logic                  hold,
`ifdef UCODE_IRQ_EN
    input  logic                  irq_req,
    output logic                  irq_ack,
`endif
    output logic [1:0]            mode,
    output logic [SC_WIDTH-1:0]   sc,
    output logic                  pc_ce,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALL = 2'd1;
    localparam logic [1:0] ST_RET  = 2'd2;
    localparam logic [1:0] ST_IRQ  = 2'd3;

    localparam logic [SC_WIDTH-1:0] SC_ZERO   = {SC_WIDTH{1'b0}};
    localparam logic [SC_WIDTH-1:0] SC_STEP   = SC_WIDTH'(3'd4);
    localparam logic [SC_WIDTH-1:0] CALL_LAST = SC_WIDTH'(4 * (CALL_LEN - 1));
    localparam logic [SC_WIDTH-1:0] RET_LAST  = SC_WIDTH'(4 * (RET_LEN - 1));
`ifdef UCODE_IRQ_EN
    localparam logic [SC_WIDTH-1:0] IRQ_LAST  = SC_WIDTH'(4 * (IRQ_LEN - 1));
`endif

    logic [1:0]          mode_q, mode_d;
    logic [SC_WIDTH-1:0] sc_q, sc_d;
    logic [SC_WIDTH-1:0] last_sc_s;
    logic [6:0]          opcode_s;
    logic                done_s;
    logic                irq_take_s;
    logic                unused_inst_hi_s;

    assign opcode_s         = inst_in[6:0];
    assign unused_inst_hi_s = ^inst_in[INST_WIDTH-1:7];

`ifdef UCODE_IRQ_EN
    logic irq_ack_q, irq_ack_d;
    assign irq_take_s = (mode_q == ST_IDLE) && !hold && irq_req;
`else
    assign irq_take_s = 1'b0;
`endif

    // Final micro-op address of the sequence currently running
    always_comb begin
        last_sc_s = SC_ZERO;
        case (mode_q)
            ST_CALL: last_sc_s = CALL_LAST;
            ST_RET:  last_sc_s = RET_LAST;
`ifdef UCODE_IRQ_EN
            ST_IRQ:  last_sc_s = IRQ_LAST;
`endif
            default: last_sc_s = SC_ZERO;
        endcase
    end

    assign done_s = (mode_q != ST_IDLE) && (sc_q == last_sc_s);

    // Next state and micro-op address; interrupt entry outranks opcode decode
    always_comb begin
        mode_d = mode_q;
        sc_d   = sc_q;
        if (hold) begin
            mode_d = mode_q;
            sc_d   = sc_q;
        end else if (mode_q == ST_IDLE) begin
            sc_d = SC_ZERO;
            if (irq_take_s) begin
                mode_d = ST_IRQ;
            end else if (opcode_s == CALL_OPC) begin
                mode_d = ST_CALL;
            end else if (opcode_s == RET_OPC) begin
                mode_d = ST_RET;
            end else begin
                mode_d = ST_IDLE;
            end
        end else if (done_s) begin
            mode_d = ST_IDLE;
            sc_d   = SC_ZERO;
        end else begin
            sc_d = sc_q + SC_STEP;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= ST_IDLE;
            sc_q   <= SC_ZERO;
        end else begin
            mode_q <= mode_d;
            sc_q   <= sc_d;
        end
    end

`ifdef UCODE_IRQ_EN
    // Acknowledge marks only the first IRQ-state cycle and freezes under hold
    always_comb begin
        irq_ack_d = irq_ack_q;
        if (hold) begin
            irq_ack_d = irq_ack_q;
        end else begin
            irq_ack_d = irq_take_s;
        end
    end

    // Acknowledge register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_ack_q <= 1'b0;
        end else begin
            irq_ack_q <= irq_ack_d;
        end
    end

    assign irq_ack = irq_ack_q;
`endif

    assign mode  = mode_q;
    assign sc    = sc_q;
    assign busy  = (mode_q != ST_IDLE);
    assign done  = done_s;
    assign pc_ce = (mode_q == ST_IDLE) && !hold && !irq_take_s;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: a step-count reference model predicts each cycle's outputs.
module tb_ucode_sequencer;
    localparam int         CLEN     = 16;
    localparam int         RLEN     = 4;
    localparam int         ILEN     = 16;
    localparam logic [6:0] CALL_OP  = 7'h70;
    localparam logic [6:0] RET_OP   = 7'h71;
    localparam logic [6:0] PLAIN_OP = 7'h33;
`ifdef UCODE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [31:0] inst_in;
    logic [1:0]  mode;
    logic [7:0]  sc;
    logic        pc_ce, busy, done;
`ifdef UCODE_IRQ_EN
    logic        irq_req, irq_ack;
`endif

    typedef struct {
        logic [1:0] mode;
        logic [7:0] sc;
        logic       pc_ce;
        logic       busy;
        logic       done;
        logic       ack;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: which sequence is running and how many micro-ops it has issued
    int   m_kind;
    int   m_k;
    logic m_ack;

    ucode_sequencer #(.RET_LEN(RLEN)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .hold(hold),
`ifdef UCODE_IRQ_EN
        .irq_req(irq_req), .irq_ack(irq_ack),
`endif
        .mode(mode), .sc(sc), .pc_ce(pc_ce), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int len_of(input int kind);
        case (kind)
            1:       return CLEN;
            2:       return RLEN;
            3:       return ILEN;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind = 0;
        m_k    = 0;
        m_ack  = 1'b0;
    endtask

    // Apply one cycle of inputs, queue the predicted outputs, then advance the model at the edge
    task automatic drive(input logic [6:0] op, input logic h, input logic irq);
        exp_t e;
        logic [31:0] w;
        bit take_irq;
        w       = $urandom;
        w[6:0]  = op;
        inst_in = w;
        hold    = h;
`ifdef UCODE_IRQ_EN
        irq_req = irq;
`endif
        take_irq = IRQ_ON && irq && (m_kind == 0) && !h;
        e.mode  = 2'(m_kind);
        e.sc    = 8'(4 * m_k);
        e.busy  = (m_kind != 0);
        e.done  = (m_kind != 0) && (m_k == len_of(m_kind) - 1);
        e.pc_ce = (m_kind == 0) && !h && !take_irq;
        e.ack   = m_ack;
        sbq.push_back(e);
        @(posedge clk);
        if (!h) begin
            m_ack = 1'b0;
            if (m_kind == 0) begin
                m_k = 0;
                if (take_irq) begin
                    m_kind = 3;
                    m_ack  = 1'b1;
                end else if (op == CALL_OP) begin
                    m_kind = 1;
                end else if (op == RET_OP) begin
                    m_kind = 2;
                end
            end else if (m_k == len_of(m_kind) - 1) begin
                m_kind = 0;
                m_k    = 0;
            end else begin
                m_k = m_k + 1;
            end
        end
        #1;
    endtask

    task automatic idle_op(input int n);
        for (int i = 0; i < n; i++) drive(7'($urandom), 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented output cycle against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("mode", {30'd0, mode}, {30'd0, e.mode});
            chk("sc", {24'd0, sc}, {24'd0, e.sc});
            chk("pc_ce", {31'd0, pc_ce}, {31'd0, e.pc_ce});
            chk("busy", {31'd0, busy}, {31'd0, e.busy});
            chk("done", {31'd0, done}, {31'd0, e.done});
`ifdef UCODE_IRQ_EN
            chk("irq_ack", {31'd0, irq_ack}, {31'd0, e.ack});
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [6:0] op;
        rst = 1'b0; hold = 1'b0; inst_in = 32'd0;
`ifdef UCODE_IRQ_EN
        irq_req = 1'b0;
`endif
        model_reset();
        #12;
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_sc", {24'd0, sc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pc_ce", {31'd0, pc_ce}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Plain opcode stays idle and advances the PC
        drive(PLAIN_OP, 1'b0, 1'b0);
        drive(PLAIN_OP, 1'b0, 1'b0);
        // Full CALL sequence, opcodes inside it ignored
        drive(CALL_OP, 1'b0, 1'b0);
        for (int i = 0; i < CLEN; i++) drive((i % 2 == 0) ? RET_OP : CALL_OP, 1'b0, 1'b0);
        drive(PLAIN_OP, 1'b0, 1'b0);
        // Short RET with a three-cycle hold at sc=8
        drive(RET_OP, 1'b0, 1'b0);
        idle_op(2);
        for (int i = 0; i < 3; i++) drive(CALL_OP, 1'b1, 1'b0);
        idle_op(3);
        // Asynchronous reset mid-CALL at sc=20, then a clean restart
        drive(CALL_OP, 1'b0, 1'b0);
        idle_op(5);
        #2 rst = 1'b0;
        #1;
        chk("arst_mode", {30'd0, mode}, 32'd0);
        chk("arst_sc", {24'd0, sc}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        drive(CALL_OP, 1'b0, 1'b0);
        idle_op(CLEN + 1);
`ifdef UCODE_IRQ_EN
        // IRQ beats CALL in the same cycle, then CALL is taken afterwards
        drive(CALL_OP, 1'b0, 1'b1);
        for (int i = 0; i < ILEN; i++) drive(CALL_OP, 1'b0, 1'($urandom_range(0, 1)));
        drive(CALL_OP, 1'b0, 1'b0);
        idle_op(CLEN);
        // IRQ raised during RET waits for idle
        drive(RET_OP, 1'b0, 1'b0);
        for (int i = 0; i < RLEN + 2; i++) drive(PLAIN_OP, 1'b0, 1'b1);
        idle_op(ILEN);
`endif
        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       op = CALL_OP;
            else if (r < 4)  op = RET_OP;
            else if (r == 4) op = PLAIN_OP;
            else             op = 7'($urandom);
            drive(op, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end
        repeat (2) @(negedge clk);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 Parameter INST_WIDTH, 32, width of the macro instruction word.
REQ-002 Parameter SC_WIDTH, 8, width of the micro-op address.
REQ-003 Parameter CALL_OPC, 7'h70, opcode (inst[6:0]) that starts the CALL sequence.
REQ-004 Parameter RET_OPC, 7'h71, opcode that starts the RET sequence.
REQ-005 Parameter CALL_LEN, 16, number of micro-ops in the CALL sequence (2..64).
REQ-006 Parameter RET_LEN, 16, number of micro-ops in the RET sequence (2..64).
REQ-007 Ports: one clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 inst_in  input  INST_WIDTH  instruction fetched from program memory.
REQ-011 hold  input  1  freezes all state while high.
REQ-012 mode  output  2  datapath instruction source: 0 program, 1 CALL ROM, 2 RET ROM, 3 IRQ ROM.
REQ-013 sc  output  SC_WIDTH  micro-op byte address into the active ROM.
REQ-014 pc_ce  output  1  program-counter enable.
REQ-015 busy  output  1  high when mode != 0.
REQ-016 done  output  1  high during the last micro-op cycle of any sequence.
REQ-017 irq_req  input  1  level interrupt request (IRQ_EN only).
REQ-018 irq_ack  output  1  one-cycle acknowledge (IRQ_EN only).

Function
REQ-019 States: IDLE(mode 0), CALL(1), RET(2), IRQ(3); mode and sc are registered.
REQ-020 IDLE: pc_ce = ~hold, except when an IRQ entry is taken that cycle.
REQ-021 IDLE, hold=0, inst_in[6:0]==CALL_OPC -> next CALL, sc=0; PC still advances that cycle, so the macro retires.
REQ-022 IDLE, hold=0, inst_in[6:0]==RET_OPC -> next RET, sc=0; PC advances.
REQ-023 In CALL/RET/IRQ: pc_ce=0; opcode decode is ignored, and macro opcodes inside microcode are not nested.
REQ-024 Active state, hold=0: sc <= sc+4 each cycle.
REQ-025 Last micro-op is sc == 4*(LEN-1), where LEN is the active sequence length; done=1 that cycle.
REQ-026 At the last micro-op with hold=0: next IDLE and sc <= 0.
REQ-027 hold=1: state, sc and irq_ack frozen; pc_ce=0; done still reflects the current sc.
REQ-028 sc never exceeds 4*(LEN-1), so no wrap occurs; the 4*(64-1)=252 maximum fits in SC_WIDTH=8.
REQ-029 With no sequence active, sc holds 0.

Reset
REQ-030 rst low asserts asynchronously: state IDLE, mode=0, sc=0, irq_ack=0, done=0, busy=0.
REQ-031 Reset mid-sequence abandons the sequence; no resumption occurs after release.
REQ-032 pc_ce reflects IDLE (=~hold) while in reset, and the PC register's own reset dominates.

Configuration
REQ-033 Macro UCODE_IRQ_EN compiles in the interrupt-entry sequence.
REQ-034 With UCODE_IRQ_EN: parameter IRQ_LEN, default 16, sets the length of the IRQ sequence.
REQ-035 With UCODE_IRQ_EN: in IDLE with hold=0 and irq_req=1, next state is IRQ and sc=0.
REQ-036 With UCODE_IRQ_EN: the IRQ entry has priority over a CALL/RET opcode in the same cycle.
REQ-037 With UCODE_IRQ_EN: pc_ce=0 in the entry cycle, so the pending instruction is refetched after the IRQ sequence.
REQ-038 With UCODE_IRQ_EN: irq_ack is registered high for exactly the first IRQ-state cycle.
REQ-039 With UCODE_IRQ_EN: irq_req is ignored outside IDLE.
REQ-040 Without UCODE_IRQ_EN: irq_req/irq_ack ports absent, mode never equals 3, and the IRQ state is not built.

Verification
REQ-041 CALL: CALL_OPC in IDLE -> pc_ce=1 that cycle; then mode=1 with sc 0,4,...,60 over 16 cycles; done at sc=60; IDLE and sc=0 next cycle.
REQ-042 RET with RET_LEN=4 and hold pulsed at sc=8 for 3 cycles -> sc stays 8, pc_ce=0; sequence resumes to 12 then IDLE after 7 active cycles total.
REQ-043 Non-macro opcode 7'h33 in IDLE -> mode=0, pc_ce=1, sc=0, busy=0.
REQ-044 Reset: rst low asynchronously mid-CALL at sc=20 -> mode=0 and sc=0 immediately; after release, CALL_OPC restarts at sc=0.
REQ-045 UCODE_IRQ_EN: irq_req=1 with CALL_OPC in the same cycle -> pc_ce=0, mode=3 next cycle, irq_ack=1 for one cycle; after 16 cycles IDLE, CALL_OPC then accepted.
REQ-046 UCODE_IRQ_EN: irq_req raised during a RET sequence -> ignored until IDLE, then IRQ entered on the first IDLE cycle.
